size_patch_writer: RTL and testbench
====================================

# size_patch_writer

Receiving end of the sequencer's size-field patch interface (`offset_addr` / `val` / `byte_size`). It accepts each patch request, queues it, and serialises it into big-endian byte writes to the output bitstream buffer. This back-fills slice, picture, frame, Y and Cb size fields after the payload has been emitted. It sits between the sequencer and the byte-wide write port of the bitstream buffer.

## Interface
- `FIFO_DEPTH`, default 8: patch request queue depth; must be a power of two ≥ 2.
- `ADDR_WIDTH`, default 32: width of the buffer byte address.
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `offset_addr`  in  32  byte address of the first (most significant) byte of the field.
- `val`  in  32  field value, right-aligned.
- `byte_size`  in  32  field length in bytes; 0 means no request this cycle.
- `mem_ready`  in  1  buffer accepts the byte presented this cycle.
- `mem_we`  out  1  byte write request.
- `mem_addr`  out  ADDR_WIDTH  byte address.
- `mem_wdata`  out  8  byte data.
- `busy`  out  1  FIFO non-empty or a patch is in flight.
- `overflow`  out  1  sticky: a valid request was dropped because the FIFO was full.
- `bad_size`  out  1  sticky: a request with an unsupported `byte_size` was dropped.
- `patch_count`  out  16  number of patches fully written; wraps at 2^16.

## Operation
- Request push: sampled every cycle. `byte_size` is compared as the full 32-bit value.
  - 1, 2 or 4: push {addr = `offset_addr[ADDR_WIDTH-1:0]`, val, size}.
  - 0: ignored.
  - Any other value: dropped, and `bad_size` is set.
- There is no input backpressure; the sequencer never waits.
- FIFO full with no pop in the same cycle: the request is dropped and `overflow` is set. Full with a simultaneous pop: the push succeeds.
- FSM states are IDLE and WRITE.
  - IDLE: if the FIFO is non-empty, pop the head into a shift register {addr, val left-justified so the MSB byte is in [31:24], remaining count}. Go to WRITE.
  - WRITE: `mem_we` = 1, `mem_addr` = current addr, `mem_wdata` = shift[31:24].
  - On `mem_we && mem_ready`: addr += 1, shift <<= 8, count -= 1.
  - When the last byte is accepted: pop the next entry if the FIFO is non-empty and stay in WRITE; otherwise go to IDLE. `patch_count` increments.
- Bytes are written big-endian: byte i (0-based) goes to addr+i and equals val[8(n-i)-1 -: 8].
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is permitted, not flagged.
- `mem_addr` and `mem_wdata` hold stable while `mem_we && !mem_ready`.
- Patches complete in FIFO order. A patch is never interleaved with another.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `overflow`=0, `bad_size`=0, `patch_count`=0; FIFO empty; FSM in IDLE.
- Latency: a request sampled at edge k into an empty, idle block gives the pop at edge k+1 and `mem_we`=1 after edge k+2.
- Throughput: one byte per cycle while `mem_ready`=1. No bubble between back-to-back patches.
- An n-byte patch occupies WRITE for exactly n cycles with `mem_ready` held high.
- `busy` rises the cycle after a successful push. It falls the cycle after the last byte of the last queued patch is accepted.
- Reset mid-operation: outputs clear asynchronously and the in-flight patch and queued entries are discarded. No partial write completes after `reset_n` falls.
- `overflow` and `bad_size` clear only on reset.

## Structure
- Shared package `size_patch_pkg`:
  - state enum {IDLE, WRITE};
  - constants `PATCH_SIZE_1`=1, `PATCH_SIZE_2`=2, `PATCH_SIZE_4`=4;
  - the packed FIFO entry typedef {addr, val, size[2:0]}.
- One sub-module, `patch_fifo`: synchronous FIFO, registered output, parameterised depth and entry width. It provides full/empty flags and supports push and pop in the same cycle.
- Top level holds the FSM, shift register, address counter and flags.

## Test plan
- Single 2-byte patch (offset_addr=0x10, val=0x1234, byte_size=2), `mem_ready`=1 → writes 0x12@0x10 then 0x34@0x11, starting 2 cycles after the request; `patch_count`=1; `busy` returns to 0.
- Sequencer burst on 5 consecutive cycles: slice 2B=0x0456@0x20, picture 4B=0x00001000@0x08, frame 4B=0x00002000@0x00, Y 2B=0x0200@0x30, Cb 2B=0x0100@0x32 → 14 contiguous byte writes in that order with no gap; `patch_count`=5; `overflow`=0.
- Backpressure: 4-byte patch 0xA1B2C3D4@0x100 with `mem_ready` toggling 1,0,0,1,1,0,1 → bytes A1,B2,C3,D4 at 0x100..0x103; addr/data are stable during stalls; each byte is written once.
- Overflow, FIFO_DEPTH=2, `mem_ready`=0: push 4 valid requests → only the first 3 are written; `overflow`=1 (the first is popped into WRITE, 2 are queued, the 4th is dropped).
- Invalid size: byte_size=3, then byte_size=0x100000002 truncated to 32 bits is 2 and is valid; then byte_size=5 → `bad_size`=1; only the size-2 request is written.
- Reset mid-patch: assert `reset_n`=0 after the 2nd byte of a 4-byte patch with 2 entries queued → `mem_we`=0 immediately; after release there are no further writes, `busy`=0 and `patch_count`=0.

Source files
------------

// File: rtl/size_patch_pkg.sv
// Shared types and constants for the size-field patch writer: FSM states,
// supported field sizes and the queued request layout.
package size_patch_pkg;

    typedef enum logic {
        IDLE,
        WRITE
    } state_e;

    localparam logic [31:0] PATCH_SIZE_1 = 32'd1;
    localparam logic [31:0] PATCH_SIZE_2 = 32'd2;
    localparam logic [31:0] PATCH_SIZE_4 = 32'd4;

    // addr is carried at full 32 bits; the top keeps only ADDR_WIDTH of it
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] val;
        logic [2:0]  size;
    } patch_entry_t;

    function automatic logic [31:0] left_justify(input logic [31:0] v, input logic [2:0] size);
        case (size)
            3'd1:    return v << 24;
            3'd2:    return v << 16;
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/patch_fifo.sv
// Synchronous FIFO with a registered head: entries land in storage first and
// move into the head register on the following edge, so empty-to-valid is one cycle.
module patch_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d, total;
    logic [WIDTH-1:0] head_q;
    logic             head_vld_q;
    logic             pop_ok, push_ok, load;

    // Capacity counts the head register, so DEPTH is the total entry limit.
    assign total   = mem_cnt_q + CNT_W'(head_vld_q);
    assign full    = (total == CNT_W'(DEPTH));
    assign empty   = (total == '0);
    assign pop_ok  = pop && head_vld_q;
    assign push_ok = push && (!full || pop_ok);
    assign load    = (!head_vld_q || pop_ok) && (mem_cnt_q != '0);

    assign head       = head_q;
    assign head_valid = head_vld_q;

    always_comb begin
        mem_cnt_d = mem_cnt_q;
        case ({push_ok, load})
            2'b10:   mem_cnt_d = mem_cnt_q + CNT_W'(1);
            2'b01:   mem_cnt_d = mem_cnt_q - CNT_W'(1);
            default: mem_cnt_d = mem_cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            mem_cnt_q <= mem_cnt_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (load) begin
                head_q     <= mem_q[rd_ptr_q];
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                head_vld_q <= 1'b1;
            end else if (pop_ok) begin
                head_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/size_patch_writer.sv
// Queues size-field patch requests and writes each one big-endian, one byte
// per accepted cycle, into the bitstream buffer.
//   state | meaning
//   IDLE  | no patch in flight; pops the queue head when one is available
//   WRITE | presenting the current byte; last accept chains straight into the next patch
module size_patch_writer
    import size_patch_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [31:0]           offset_addr,
    input  logic [31:0]           val,
    input  logic [31:0]           byte_size,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  busy,
    output logic                  overflow,
    output logic                  bad_size,
    output logic [15:0]           patch_count
);
    localparam int ENTRY_W = $bits(patch_entry_t);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           shift_q, shift_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [15:0]           patch_cnt_q, patch_cnt_d;
    logic                  ovf_q, bad_q;

    logic                  size_ok, req_bad, pop, we;
    logic                  fifo_full, fifo_empty, head_valid;
    logic [ENTRY_W-1:0]    fifo_head;
    patch_entry_t          push_entry, head_entry;

    assign size_ok = (byte_size == PATCH_SIZE_1) || (byte_size == PATCH_SIZE_2) ||
                     (byte_size == PATCH_SIZE_4);
    assign req_bad = (byte_size != '0) && !size_ok;

    assign push_entry = '{addr: 32'(offset_addr[ADDR_WIDTH-1:0]), val: val, size: byte_size[2:0]};
    assign head_entry = patch_entry_t'(fifo_head);

    patch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (size_ok),
        .push_data  (push_entry),
        .pop        (pop),
        .head       (fifo_head),
        .head_valid (head_valid),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        patch_cnt_d = patch_cnt_q;
        pop         = 1'b0;
        we          = 1'b0;
        case (state_q)
            IDLE: begin
                if (head_valid) begin
                    pop     = 1'b1;
                    state_d = WRITE;
                    addr_d  = head_entry.addr[ADDR_WIDTH-1:0];
                    shift_d = left_justify(head_entry.val, head_entry.size);
                    cnt_d   = head_entry.size;
                end
            end
            WRITE: begin
                we = 1'b1;
                if (mem_ready) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    shift_d = shift_q << 8;
                    cnt_d   = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        patch_cnt_d = patch_cnt_q + 16'd1;
                        if (head_valid) begin
                            pop     = 1'b1;
                            addr_d  = head_entry.addr[ADDR_WIDTH-1:0];
                            shift_d = left_justify(head_entry.val, head_entry.size);
                            cnt_d   = head_entry.size;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            patch_cnt_q <= '0;
            ovf_q       <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            patch_cnt_q <= patch_cnt_d;
            if (size_ok && fifo_full && !pop) ovf_q <= 1'b1;
            if (req_bad) bad_q <= 1'b1;
        end
    end

    assign mem_we      = we;
    assign mem_addr    = addr_q;
    assign mem_wdata   = shift_q[31:24];
    assign busy        = (state_q == WRITE) || !fifo_empty;
    assign overflow    = ovf_q;
    assign bad_size    = bad_q;
    assign patch_count = patch_cnt_q;

endmodule

// File: tb/tb_size_patch_writer.sv
// Directed bench for size_patch_writer: a default-depth instance for the
// main scenarios and a depth-2 instance for queue overflow.
module tb_size_patch_writer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] offset_addr = '0, val = '0, byte_size = '0;
    logic        mem_ready = 1'b1;
    logic        mem_we, busy, overflow, bad_size;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [15:0] patch_count;

    logic [31:0] o_offset_addr = '0, o_val = '0, o_byte_size = '0;
    logic        o_mem_ready = 1'b1;
    logic        o_mem_we, o_busy, o_overflow, o_bad_size;
    logic [31:0] o_mem_addr;
    logic [7:0]  o_mem_wdata;
    logic [15:0] o_patch_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] wa[$];
    logic [7:0]  wd[$];
    int          wc[$];
    logic [31:0] oa[$];
    logic [7:0]  od[$];

    size_patch_writer #(.FIFO_DEPTH(8), .ADDR_WIDTH(32)) u_dut (
        .clock(clock), .reset_n(reset_n), .offset_addr(offset_addr), .val(val),
        .byte_size(byte_size), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .overflow(overflow), .bad_size(bad_size),
        .patch_count(patch_count)
    );

    size_patch_writer #(.FIFO_DEPTH(2), .ADDR_WIDTH(32)) u_ovf (
        .clock(clock), .reset_n(reset_n), .offset_addr(o_offset_addr), .val(o_val),
        .byte_size(o_byte_size), .mem_ready(o_mem_ready), .mem_we(o_mem_we), .mem_addr(o_mem_addr),
        .mem_wdata(o_mem_wdata), .busy(o_busy), .overflow(o_overflow), .bad_size(o_bad_size),
        .patch_count(o_patch_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (mem_we && mem_ready) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end
        if (o_mem_we && o_mem_ready) begin
            oa.push_back(o_mem_addr);
            od.push_back(o_mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] v, input logic [31:0] s);
        offset_addr = a; val = v; byte_size = s;
        step();
        byte_size = '0;
    endtask

    task automatic send_o(input logic [31:0] a, input logic [31:0] v, input logic [31:0] s);
        o_offset_addr = a; o_val = v; o_byte_size = s;
        step();
        o_byte_size = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        byte_size = '0; o_byte_size = '0;
        mem_ready = 1'b1; o_mem_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        wa.delete(); wd.delete(); wc.delete();
        oa.delete(); od.delete();
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            step();
            n++;
        end
        chk(tag, {63'd0, busy}, 64'd0);
    endtask

    task automatic chk_write(input string tag, input int idx, input logic [31:0] a, input logic [7:0] d);
        if (idx < wa.size()) begin
            chk({tag, "_addr"}, wa[idx], a);
            chk({tag, "_data"}, wd[idx], d);
        end else begin
            chk({tag, "_missing"}, 64'(idx), 64'(wa.size()));
        end
    endtask

    logic [31:0] burst_a[14] = '{32'h20, 32'h21, 32'h08, 32'h09, 32'h0A, 32'h0B,
                                 32'h00, 32'h01, 32'h02, 32'h03, 32'h30, 32'h31, 32'h32, 32'h33};
    logic [7:0]  burst_d[14] = '{8'h04, 8'h56, 8'h00, 8'h00, 8'h10, 8'h00,
                                 8'h00, 8'h00, 8'h20, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00};
    logic        bp_rdy[7]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0]  bp_d[4]     = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    initial begin
        int acc;
        #2;
        // reset state, held in reset
        chk("rst_we", {63'd0, mem_we}, 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        chk("rst_bad", {63'd0, bad_size}, 64'd0);
        chk("rst_pcnt", patch_count, 64'd0);

        // single 2-byte patch, cycle-exact
        do_reset();
        send(32'h10, 32'h1234, 32'd2);
        chk("t1_busy_k", {63'd0, busy}, 64'd1);
        chk("t1_we_k", {63'd0, mem_we}, 64'd0);
        step();
        chk("t1_we_k1", {63'd0, mem_we}, 64'd0);
        step();
        chk("t1_we_k2", {63'd0, mem_we}, 64'd1);
        chk("t1_addr0", mem_addr, 64'h10);
        chk("t1_data0", mem_wdata, 64'h12);
        step();
        chk("t1_addr1", mem_addr, 64'h11);
        chk("t1_data1", mem_wdata, 64'h34);
        step();
        chk("t1_we_end", {63'd0, mem_we}, 64'd0);
        chk("t1_busy_end", {63'd0, busy}, 64'd0);
        chk("t1_pcnt", patch_count, 64'd1);
        chk("t1_nwr", 64'(wa.size()), 64'd2);

        // sequencer burst on consecutive cycles
        do_reset();
        send(32'h20, 32'h0456, 32'd2);
        send(32'h08, 32'h00001000, 32'd4);
        send(32'h00, 32'h00002000, 32'd4);
        send(32'h30, 32'h0200, 32'd2);
        send(32'h32, 32'h0100, 32'd2);
        wait_idle("t2_timeout", 100);
        chk("t2_nwr", 64'(wa.size()), 64'd14);
        for (int i = 0; i < 14; i++) chk_write("t2_wr", i, burst_a[i], burst_d[i]);
        if (wc.size() == 14) chk("t2_nogap", 64'(wc[13] - wc[0]), 64'd13);
        chk("t2_pcnt", patch_count, 64'd5);
        chk("t2_ovf", {63'd0, overflow}, 64'd0);

        // backpressure with stalls
        do_reset();
        mem_ready = 1'b0;
        send(32'h100, 32'hA1B2C3D4, 32'd4);
        step();
        step();
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            mem_ready = bp_rdy[i];
            chk("t3_we", {63'd0, mem_we}, 64'd1);
            chk("t3_addr", mem_addr, 64'(32'h100 + acc));
            chk("t3_data", mem_wdata, 64'(bp_d[acc]));
            step();
            if (bp_rdy[i]) acc++;
        end
        mem_ready = 1'b1;
        chk("t3_we_end", {63'd0, mem_we}, 64'd0);
        chk("t3_nwr", 64'(wa.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk_write("t3_wr", i, 32'h100 + i, bp_d[i]);
        chk("t3_pcnt", patch_count, 64'd1);

        // overflow on a depth-2 queue with the buffer stalled
        do_reset();
        o_mem_ready = 1'b0;
        send_o(32'h40, 32'h11, 32'd1);
        send_o(32'h41, 32'h22, 32'd1);
        send_o(32'h42, 32'h33, 32'd1);
        send_o(32'h43, 32'h44, 32'd1);
        step();
        chk("t4_ovf", {63'd0, o_overflow}, 64'd1);
        o_mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("t4_busy", {63'd0, o_busy}, 64'd0);
        chk("t4_nwr", 64'(oa.size()), 64'd3);
        for (int i = 0; i < 3 && i < oa.size(); i++) begin
            chk("t4_addr", oa[i], 64'(32'h40 + i));
            chk("t4_data", od[i], 64'(8'h11 * (i + 1)));
        end
        chk("t4_pcnt", o_patch_count, 64'd3);

        // unsupported sizes
        do_reset();
        send(32'h50, 32'hAA, 32'd3);
        chk("t5_bad_early", {63'd0, bad_size}, 64'd1);
        send(32'h60, 32'hBEEF, 32'(64'h1_0000_0002));
        send(32'h70, 32'hCC, 32'd5);
        wait_idle("t5_timeout", 50);
        chk("t5_bad", {63'd0, bad_size}, 64'd1);
        chk("t5_nwr", 64'(wa.size()), 64'd2);
        chk_write("t5_wr0", 0, 32'h60, 8'hBE);
        chk_write("t5_wr1", 1, 32'h61, 8'hEF);
        chk("t5_pcnt", patch_count, 64'd1);

        // reset in the middle of a patch with entries queued
        do_reset();
        send(32'h200, 32'hDEADBEEF, 32'd4);
        send(32'h300, 32'h1111, 32'd2);
        send(32'h400, 32'h2222, 32'd2);
        step();
        step();
        chk("t6_nwr_pre", 64'(wa.size()), 64'd2);
        reset_n = 1'b0;
        #1;
        chk("t6_we_async", {63'd0, mem_we}, 64'd0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("t6_nwr_post", 64'(wa.size()), 64'd2);
        chk("t6_busy", {63'd0, busy}, 64'd0);
        chk("t6_pcnt", patch_count, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
